// File: rtl/mult_pkg.sv
// ============================================================================
// Module  : mult_pkg
// Brief   : Shared FSM encoding and sizing helper for the shared multiplier.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Never returns less than 1 so that single-entry fields keep a legal width.
    function automatic int clog2_f(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_rr_arbiter.sv
// ============================================================================
// Module  : mult_rr_arbiter
// Brief   : Combinational round-robin grant starting the scan at i_rr_ptr.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module mult_rr_arbiter
    import mult_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = clog2_f(NREQ)
) (
    input  logic [NREQ-1:0] i_req_valid,
    input  logic [IW-1:0]   i_rr_ptr,
    input  logic            i_enable,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_grant_idx,
    output logic            o_any
);

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (i_enable && !o_any && i_req_valid[(int'(i_rr_ptr) + k) % NREQ]) begin
                o_any                                     = 1'b1;
                o_grant[(int'(i_rr_ptr) + k) % NREQ]      = 1'b1;
                o_grant_idx = IW'((int'(i_rr_ptr) + k) % NREQ);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_rr_scheduler.sv
// ============================================================================
// Module  : mult_rr_scheduler
// Brief   : Round-robin shared shift-add multiplier with tagged result port.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module mult_rr_scheduler
    import mult_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NREQ   = 4,
    parameter int SIGNED = 0,
    localparam int IW    = clog2_f(NREQ),
    localparam int CW    = clog2_f(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*WIDTH-1:0]    res_data,
    output logic [IW-1:0]         res_id,
    output logic                  busy
);

    logic [1:0]         r_state;
    logic [IW-1:0]      r_rr_ptr;
    logic [IW-1:0]      r_id;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_res_valid;
    logic [2*WIDTH-1:0] r_res_data;
    logic [IW-1:0]      r_res_id;
    logic               r_busy;

    logic               w_enable;
    logic               w_any;
    logic [IW-1:0]      w_gidx;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_result;
    logic               w_last;

    // Gating with rst_n keeps req_ready low while reset is held.
    assign w_enable = (r_state == ST_IDLE) && rst_n;

    mult_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req_valid (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .i_enable    (w_enable),
        .o_grant     (req_ready),
        .o_grant_idx (w_gidx),
        .o_any       (w_any)
    );

    assign w_sel_a = req_a[w_gidx*WIDTH +: WIDTH];
    assign w_sel_b = req_b[w_gidx*WIDTH +: WIDTH];

    generate
        if (SIGNED != 0) begin : g_signed
            // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude.
            assign w_mag_a = w_sel_a[WIDTH-1] ? (WIDTH'(0) - w_sel_a) : w_sel_a;
            assign w_mag_b = w_sel_b[WIDTH-1] ? (WIDTH'(0) - w_sel_b) : w_sel_b;
            assign w_neg   = w_sel_a[WIDTH-1] ^ w_sel_b[WIDTH-1];
        end else begin : g_unsigned
            assign w_mag_a = w_sel_a;
            assign w_mag_b = w_sel_b;
            assign w_neg   = 1'b0;
        end
    endgenerate

    assign w_a_ext    = {{WIDTH{1'b0}}, r_a};
    assign w_addend   = r_b[r_cnt] ? (w_a_ext << r_cnt) : '0;
    assign w_acc_next = r_acc + w_addend;
    assign w_result   = r_neg ? ((2*WIDTH)'(0) - w_acc_next) : w_acc_next;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_neg       <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_a      <= w_mag_a;
                        r_b      <= w_mag_b;
                        r_neg    <= w_neg;
                        r_id     <= w_gidx;
                        r_rr_ptr <= (w_gidx == IW'(NREQ - 1)) ? '0 : w_gidx + IW'(1);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_res_data  <= w_result;
                        r_res_id    <= r_id;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mult_rr_scheduler.sv
// ============================================================================
// Module  : tb_mult_rr_scheduler
// Brief   : Unsigned and signed instances driven in lockstep, checked vs. model.
// Rev     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mult_rr_scheduler;

    localparam int W = 8;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic             res_ready = 1'b0;

    logic [N-1:0]     rdy_u, rdy_s;
    logic             vld_u, vld_s;
    logic [2*W-1:0]   dat_u, dat_s;
    logic [1:0]       id_u, id_s;
    logic             busy_u, busy_s;

    always #5 clk = ~clk;

    mult_rr_scheduler #(.WIDTH(W), .NREQ(N), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_u),
        .req_a(req_a), .req_b(req_b), .res_valid(vld_u), .res_ready(res_ready),
        .res_data(dat_u), .res_id(id_u), .busy(busy_u)
    );

    mult_rr_scheduler #(.WIDTH(W), .NREQ(N), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_s),
        .req_a(req_a), .req_b(req_b), .res_valid(vld_s), .res_ready(res_ready),
        .res_data(dat_s), .res_id(id_s), .busy(busy_s)
    );

    int total = 0;
    int bad   = 0;
    int ptr   = 0;

    typedef struct {
        logic        rst_before;
        logic [3:0]  mask;
        logic [31:0] ap;
        logic [31:0] bp;
        int          hold;
        int          eid;
        logic [15:0] eu;
        logic [15:0] es;
    } vec_t;

    vec_t tbl [15];

    logic [3:0]  rm;
    logic [31:0] rap, rbp;
    int          rid, rh;
    logic [15:0] reu, res_e;
    bit          seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [15:0] prod_u(input logic [7:0] a, input logic [7:0] b);
        int x;
        x = int'(a) * int'(b);
        return x[15:0];
    endfunction

    function automatic logic [15:0] prod_s(input logic [7:0] a, input logic [7:0] b);
        int sa, sb, x;
        sa = $signed(a);
        sb = $signed(b);
        x  = sa * sb;
        return x[15:0];
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #3;
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        chk("rst_outs_u", {8'h00, vld_u, busy_u, rdy_u, dat_u, id_u}, 32'h0);
        chk("rst_outs_s", {8'h00, vld_s, busy_s, rdy_s, dat_s, id_s}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = '0;
        ptr = 0;
    endtask

    task automatic do_op(input logic [3:0] m, input logic [31:0] ap, input logic [31:0] bp,
                         input int hold, input int eid, input logic [15:0] eu, input logic [15:0] es);
        int          n;
        bit          stable;
        logic [15:0] hd_u, hd_s;
        logic [1:0]  hi_u, hi_s;
        req_valid = m;
        req_a     = ap;
        req_b     = bp;
        res_ready = (hold == 0);
        #1;
        chk("grant_u", rdy_u, 32'd1 << eid);
        chk("grant_s", rdy_s, 32'd1 << eid);
        @(posedge clk);
        #1;
        chk("accept", {rdy_u, rdy_s, busy_u, busy_s, vld_u, vld_s}, {8'h00, 2'b11, 2'b00});
        n = 0;
        while (!vld_u && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, 8);
        chk("vld_s", vld_s, 1);
        chk("data_u", dat_u, eu);
        chk("data_s", dat_s, es);
        chk("id_u", id_u, eid);
        chk("id_s", id_s, eid);
        if (hold > 0) begin
            stable = 1;
            hd_u = dat_u; hd_s = dat_s; hi_u = id_u; hi_s = id_s;
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (!(vld_u && vld_s && busy_u && busy_s && dat_u == hd_u && dat_s == hd_s &&
                      id_u == hi_u && id_s == hi_s && rdy_u == 0 && rdy_s == 0))
                    stable = 0;
            end
            chk("hold_stable", stable, 1);
            res_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("consume", {vld_u, vld_s, busy_u, busy_s}, 0);
        ptr = (eid + 1) % N;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b1, 4'b0100, 32'h000D0000, 32'h000B0000, 0,  2, 16'h008F, 16'h008F};
        tbl[1]  = '{1'b1, 4'b1111, 32'h04030201, 32'h02020202, 0,  0, 16'h0002, 16'h0002};
        tbl[2]  = '{1'b0, 4'b1111, 32'h04030201, 32'h02020202, 0,  1, 16'h0004, 16'h0004};
        tbl[3]  = '{1'b0, 4'b1111, 32'h04030201, 32'h02020202, 0,  2, 16'h0006, 16'h0006};
        tbl[4]  = '{1'b0, 4'b1111, 32'h04030201, 32'h02020202, 0,  3, 16'h0008, 16'h0008};
        tbl[5]  = '{1'b0, 4'b1111, 32'h04030201, 32'h02020202, 0,  0, 16'h0002, 16'h0002};
        tbl[6]  = '{1'b0, 4'b1111, 32'h04030201, 32'h02020202, 20, 1, 16'h0004, 16'h0004};
        tbl[7]  = '{1'b0, 4'b0001, 32'h00000080, 32'h00000080, 0,  0, 16'h4000, 16'h4000};
        tbl[8]  = '{1'b0, 4'b0001, 32'h00000080, 32'h0000007F, 0,  0, 16'h3F80, 16'hC080};
        tbl[9]  = '{1'b0, 4'b0001, 32'h000000FF, 32'h00000001, 0,  0, 16'h00FF, 16'hFFFF};
        tbl[10] = '{1'b0, 4'b0001, 32'h00000000, 32'h000000FB, 0,  0, 16'h0000, 16'h0000};
        tbl[11] = '{1'b0, 4'b0001, 32'h000000FF, 32'h000000FF, 0,  0, 16'hFE01, 16'h0001};
        tbl[12] = '{1'b0, 4'b0001, 32'h000000FF, 32'h00000000, 0,  0, 16'h0000, 16'h0000};
        tbl[13] = '{1'b0, 4'b0001, 32'h00000000, 32'h000000FF, 0,  0, 16'h0000, 16'h0000};
        tbl[14] = '{1'b0, 4'b1010, 32'h55008000, 32'h33000100, 0,  1, 16'h0080, 16'hFF80};

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].rst_before) do_reset();
            do_op(tbl[i].mask, tbl[i].ap, tbl[i].bp, tbl[i].hold, tbl[i].eid, tbl[i].eu, tbl[i].es);
        end

        // Abort an operation mid-flight after a completed one left res_data non-zero.
        do_op(4'b0100, 32'h000D0000, 32'h000B0000, 0, rr_pick(4'b0100, ptr), 16'h008F, 16'h008F);
        req_valid = 4'b0010;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_busy", {busy_u, busy_s}, 2'b11);
        #2;
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        chk("midrst_u", {8'h00, vld_u, busy_u, rdy_u, dat_u, id_u}, 32'h0);
        chk("midrst_s", {8'h00, vld_s, busy_s, rdy_s, dat_s, id_s}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = '0;
        ptr = 0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (vld_u || vld_s || busy_u || busy_s) seen = 1;
        end
        chk("no_stale", seen, 0);
        do_op(4'b1111, 32'h04030201, 32'h02020202, 0, 0, 16'h0002, 16'h0002);

        for (int r = 0; r < 40; r++) begin
            rm    = 4'($urandom_range(1, 15));
            rap   = $urandom;
            rbp   = $urandom;
            rh    = $urandom_range(0, 3);
            rid   = rr_pick(rm, ptr);
            reu   = prod_u(rap[rid*8 +: 8], rbp[rid*8 +: 8]);
            res_e = prod_s(rap[rid*8 +: 8], rbp[rid*8 +: 8]);
            do_op(rm, rap, rbp, rh, rid, reu, res_e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
